led_uart_reporter: RTL and testbench

- Downstream consumer of the 8-bit running-light LED pattern.
- Watches the LED vector and, on every change, transmits an ASCII status line over a UART TX pin, 8N1.
- Lets a host terminal log the LED sequence.
- Sits between the LED shifter output and the board UART TX pin, in the same 25 MHz clock domain.

---
 rtl/led_uart_pkg.sv | 65 ++++++
 rtl/uart_tx_byte.sv | 60 ++++++
 rtl/led_uart_reporter.sv | 140 ++++++++++++++
 tb/tb_led_uart_reporter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_uart_pkg.sv
// Shared constants for the LED-to-UART status reporter: ASCII codes, frame FSM
// encodings, frame lengths. Build option: LED_UART_HEX_FORMAT_EN selects the 8-byte hex frame.
`timescale 1ns/1ps
package led_uart_pkg;

    localparam logic [7:0] ASCII_L  = 8'h4C;
    localparam logic [7:0] ASCII_E  = 8'h45;
    localparam logic [7:0] ASCII_D  = 8'h44;
    localparam logic [7:0] ASCII_EQ = 8'h3D;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_1  = 8'h31;
    localparam logic [7:0] ASCII_A  = 8'h41;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_SEND = 3'd2;
    localparam logic [2:0] ST_NEXT = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam int unsigned FRAME_LEN_BIN = 14;
    localparam int unsigned FRAME_LEN_HEX = 8;
`ifdef LED_UART_HEX_FORMAT_EN
    localparam int unsigned FRAME_LEN = FRAME_LEN_HEX;
`else
    localparam int unsigned FRAME_LEN = FRAME_LEN_BIN;
`endif
    localparam logic [3:0] FRAME_LAST = 4'(FRAME_LEN - 1);

    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        logic [7:0] c;
        if (nib < 4'd10) begin
            c = ASCII_0 + {4'd0, nib};
        end else begin
            c = ASCII_A + {4'd0, nib} - 8'd10;
        end
        return c;
    endfunction

    // Character at position idx of the status line describing LED value val.
    function automatic logic [7:0] frame_char(input logic [3:0] idx, input logic [7:0] val);
        logic [7:0] c;
        case (idx)
            4'd0: c = ASCII_L;
            4'd1: c = ASCII_E;
            4'd2: c = ASCII_D;
            4'd3: c = ASCII_EQ;
`ifdef LED_UART_HEX_FORMAT_EN
            4'd4: c = hex_char(val[7:4]);
            4'd5: c = hex_char(val[3:0]);
            4'd6: c = ASCII_CR;
            4'd7: c = ASCII_LF;
`else
            4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11:
                c = val[3'(4'd11 - idx)] ? ASCII_1 : ASCII_0;
            4'd12: c = ASCII_CR;
            4'd13: c = ASCII_LF;
`endif
            default: c = ASCII_LF;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter: baud counter plus a 10-bit frame shift register whose
// LSB drives the line directly, so the output is registered and idles high.
`timescale 1ns/1ps
module uart_tx_byte #(
    parameter int unsigned CLKS_PER_BIT = 217
) (
    input  logic       ext_clk_25m,
    input  logic       ext_rst_n,
    input  logic       i_start,
    input  logic [7:0] i_data,
    output logic       o_tx,
    output logic       o_done
);

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    logic [15:0] r_baud_cnt;
    logic [3:0]  r_bit_cnt;
    logic [9:0]  r_shift;
    logic        r_active;
    logic        r_done;

    // Baud timing and bit shifting; start is only honoured while idle.
    always_ff @(posedge ext_clk_25m or negedge ext_rst_n) begin
        if (!ext_rst_n) begin
            r_baud_cnt <= 16'd0;
            r_bit_cnt  <= 4'd0;
            r_shift    <= 10'h3FF;
            r_active   <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (!r_active) begin
                if (i_start) begin
                    r_shift    <= {1'b1, i_data, 1'b0};
                    r_baud_cnt <= 16'd0;
                    r_bit_cnt  <= 4'd0;
                    r_active   <= 1'b1;
                end else begin
                    r_shift <= 10'h3FF;
                end
            end else if (r_baud_cnt == BAUD_LAST) begin
                r_baud_cnt <= 16'd0;
                r_shift    <= {1'b1, r_shift[9:1]};
                if (r_bit_cnt == 4'd9) begin
                    r_active <= 1'b0;
                    r_done   <= 1'b1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end
            end else begin
                r_baud_cnt <= r_baud_cnt + 16'd1;
            end
        end
    end

    assign o_tx   = r_shift[0];
    assign o_done = r_done;

endmodule

// File: rtl/led_uart_reporter.sv
// Watches the LED pattern and sends "LED=<bits>\r\n" (or "LED=<hex>\r\n" when
// LED_UART_HEX_FORMAT_EN is defined) over 8N1 UART on every reported change.
`timescale 1ns/1ps
module led_uart_reporter
    import led_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT    = 217,
    parameter int unsigned REPORT_ON_RESET = 1
) (
    input  logic       ext_clk_25m,
    input  logic       ext_rst_n,
    input  logic [7:0] led_in,
    input  logic       report_en,
    output logic       uart_tx,
    output logic       busy,
    output logic       frame_done,
    output logic       overrun
);

    localparam logic RPT_INIT = (REPORT_ON_RESET != 0);

    logic [7:0] r_led_q;
    logic [7:0] r_last_rep;
    logic [7:0] r_snapshot;
    logic       r_pending;
    logic       r_report_req;
    logic       r_primed;
    logic [2:0] r_state;
    logic [3:0] r_idx;
    logic       r_busy;
    logic       r_frame_done;
    logic       r_overrun;

    logic       w_change;
    logic       w_in_frame;
    logic       w_start_frame;
    logic [7:0] w_char;
    logic       w_tx_done;

    assign w_change      = (r_led_q != r_last_rep);
    assign w_in_frame    = (r_state != ST_IDLE);
    // r_primed holds off the reset report until led_q carries a real sample.
    assign w_start_frame = (r_state == ST_IDLE) && r_primed && report_en
                           && (w_change || r_report_req);
    assign w_char        = frame_char(r_idx, r_snapshot);

    // Input register and post-reset settle flag.
    always_ff @(posedge ext_clk_25m or negedge ext_rst_n) begin
        if (!ext_rst_n) begin
            r_led_q  <= 8'h00;
            r_primed <= 1'b0;
        end else begin
            r_led_q  <= led_in;
            r_primed <= 1'b1;
        end
    end

    // Change tracking: pending latches during a frame, mirrors the live compare while idle.
    always_ff @(posedge ext_clk_25m or negedge ext_rst_n) begin
        if (!ext_rst_n) begin
            r_last_rep   <= 8'h00;
            r_snapshot   <= 8'h00;
            r_pending    <= RPT_INIT;
            r_report_req <= RPT_INIT;
            r_overrun    <= 1'b0;
        end else begin
            r_overrun <= w_in_frame && r_pending && (led_in != r_led_q);
            if (w_start_frame) begin
                r_snapshot   <= r_led_q;
                r_last_rep   <= r_led_q;
                r_pending    <= 1'b0;
                r_report_req <= 1'b0;
            end else if (w_in_frame) begin
                r_pending <= r_pending | w_change;
            end else begin
                r_pending <= w_change | r_report_req;
            end
        end
    end

    // Frame sequencer: one LOAD/SEND/NEXT pass per character, then a DONE pulse.
    always_ff @(posedge ext_clk_25m or negedge ext_rst_n) begin
        if (!ext_rst_n) begin
            r_state      <= ST_IDLE;
            r_idx        <= 4'd0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start_frame) begin
                        r_idx   <= 4'd0;
                        r_busy  <= 1'b1;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: r_state <= ST_SEND;
                ST_SEND: begin
                    if (w_tx_done) begin
                        r_state <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (r_idx == FRAME_LAST) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_idx   <= r_idx + 4'd1;
                        r_state <= ST_LOAD;
                    end
                end
                ST_DONE: begin
                    r_frame_done <= 1'b1;
                    r_busy       <= 1'b0;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx_byte (
        .ext_clk_25m (ext_clk_25m),
        .ext_rst_n   (ext_rst_n),
        .i_start     (r_state == ST_LOAD),
        .i_data      (w_char),
        .o_tx        (uart_tx),
        .o_done      (w_tx_done)
    );

    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_led_uart_reporter.sv
// Directed bench for led_uart_reporter: decodes the UART line sample-by-sample
// and compares each character against hand-derived status lines.
`timescale 1ns/1ps
module tb_led_uart_reporter;

    localparam int CPB = 8;
`ifdef LED_UART_HEX_FORMAT_EN
    localparam int NBYTES = 8;
`else
    localparam int NBYTES = 14;
`endif

    logic       ext_clk_25m = 1'b0;
    logic       ext_rst_n   = 1'b0;
    logic [7:0] led_in      = 8'h01;
    logic       report_en   = 1'b1;
    logic       uart_tx;
    logic       busy;
    logic       frame_done;
    logic       overrun;

    int n_cmp = 0;
    int n_bad = 0;
    int n_fdone = 0;
    int n_ovr = 0;
    int n_busy = 0;
    int n_txlow = 0;

    always #20 ext_clk_25m = ~ext_clk_25m;

    led_uart_reporter #(
        .CLKS_PER_BIT    (CPB),
        .REPORT_ON_RESET (1)
    ) dut (
        .ext_clk_25m (ext_clk_25m),
        .ext_rst_n   (ext_rst_n),
        .led_in      (led_in),
        .report_en   (report_en),
        .uart_tx     (uart_tx),
        .busy        (busy),
        .frame_done  (frame_done),
        .overrun     (overrun)
    );

    // Event counters sampled away from the active edge.
    always @(negedge ext_clk_25m) begin
        if (frame_done === 1'b1) n_fdone <= n_fdone + 1;
        if (overrun === 1'b1)    n_ovr   <= n_ovr + 1;
        if (busy === 1'b1)       n_busy  <= n_busy + 1;
        if (uart_tx === 1'b0)    n_txlow <= n_txlow + 1;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_char(input int idx, input logic [7:0] v);
        logic [3:0] nib;
        logic [2:0] sel;
        case (idx)
            0: return 8'h4C;
            1: return 8'h45;
            2: return 8'h44;
            3: return 8'h3D;
            default: ;
        endcase
`ifdef LED_UART_HEX_FORMAT_EN
        if (idx == 4) nib = v[7:4];
        else if (idx == 5) nib = v[3:0];
        else return (idx == 6) ? 8'h0D : 8'h0A;
        return (nib < 4'd10) ? (8'h30 + {4'd0, nib}) : (8'h37 + {4'd0, nib});
`else
        if (idx <= 11) begin
            sel = 3'(11 - idx);
            return v[sel] ? 8'h31 : 8'h30;
        end
        return (idx == 12) ? 8'h0D : 8'h0A;
`endif
    endfunction

    // Receive nbytes characters; the first start bit may take first_budget samples,
    // later ones at most 5 samples after the 8 checked stop-bit samples.
    task automatic recv_frame(input logic [7:0] v, input int first_budget,
                              input string name, input int nbytes);
        int         glitch;
        int         budget;
        logic       s;
        logic [7:0] b;
        glitch = 0;
        for (int i = 0; i < nbytes; i++) begin
            budget = (i == 0) ? first_budget : 5;
            s = 1'b1;
            for (int w = 0; w < budget && s !== 1'b0; w++) begin
                @(negedge ext_clk_25m);
                s = uart_tx;
            end
            if (s !== 1'b0) begin
                chk_eq($sformatf("%s.start%0d", name, i), {31'd0, s}, 32'd0);
                return;
            end
            for (int k = 1; k < CPB; k++) begin
                @(negedge ext_clk_25m);
                if (uart_tx !== 1'b0) glitch++;
            end
            for (int j = 0; j < 8; j++) begin
                @(negedge ext_clk_25m);
                b[j] = uart_tx;
                for (int k = 1; k < CPB; k++) begin
                    @(negedge ext_clk_25m);
                    if (uart_tx !== b[j]) glitch++;
                end
            end
            for (int k = 0; k < CPB; k++) begin
                @(negedge ext_clk_25m);
                if (uart_tx !== 1'b1) glitch++;
            end
            chk_eq($sformatf("%s.byte%0d", name, i), {24'd0, b}, {24'd0, exp_char(i, v)});
        end
        chk_eq({name, ".bitwidth"}, glitch, 32'd0);
    endtask

    task automatic wait_fdone(input int base, input string name);
        for (int c = 0; c < 40 && n_fdone == base; c++) begin
            @(posedge ext_clk_25m);
            #1;
        end
        chk_eq({name, ".frame_done"}, n_fdone - base, 32'd1);
    endtask

    initial begin
        int fd0, ovr0, tl0, b0, lo, hi;

        // Reset state
        repeat (3) @(negedge ext_clk_25m);
        chk_eq("rst.uart_tx", {31'd0, uart_tx}, 32'd1);
        chk_eq("rst.busy", {31'd0, busy}, 32'd0);
        chk_eq("rst.frame_done", {31'd0, frame_done}, 32'd0);
        chk_eq("rst.overrun", {31'd0, overrun}, 32'd0);

        // Automatic report after reset release
        fd0 = n_fdone;
        ext_rst_n = 1'b1;
        recv_frame(8'h01, 10, "boot", NBYTES);
        wait_fdone(fd0, "boot");
        repeat (5) @(negedge ext_clk_25m);
        chk_eq("boot.busy_after", {31'd0, busy}, 32'd0);
        chk_eq("boot.fdone_once", n_fdone - fd0, 32'd1);

        // Idle change: start bit two edges after the capturing edge
        ovr0 = n_ovr;
        fd0  = n_fdone;
        @(negedge ext_clk_25m);
        led_in = 8'h80;
        @(posedge ext_clk_25m); #1;
        chk_eq("lat.edge_k", {31'd0, uart_tx}, 32'd1);
        @(posedge ext_clk_25m); #1;
        chk_eq("lat.edge_k1", {31'd0, uart_tx}, 32'd1);
        chk_eq("lat.busy_k1", {31'd0, busy}, 32'd1);
        @(posedge ext_clk_25m); #1;
        chk_eq("lat.edge_k2", {31'd0, uart_tx}, 32'd0);
        fork
            recv_frame(8'h80, 4, "f80", NBYTES);
            begin
                repeat (40) @(negedge ext_clk_25m);
                chk_eq("f80.no_overrun", n_ovr - ovr0, 32'd0);
                led_in = 8'h40;
                repeat (40) @(negedge ext_clk_25m);
                led_in = 8'h20;
            end
        join
        wait_fdone(fd0, "f80");

        // Follow-up frame carries only the latest value
        fd0 = n_fdone;
        recv_frame(8'h20, 8, "f20", NBYTES);
        wait_fdone(fd0, "f20");
        chk_eq("f20.overrun_once", n_ovr - ovr0, 32'd1);
        tl0 = n_txlow;
        repeat (40) @(negedge ext_clk_25m);
        chk_eq("f20.no_extra_tx", n_txlow - tl0, 32'd0);
        chk_eq("f20.busy_idle", {31'd0, busy}, 32'd0);

        // report_en low holds transmission until it rises
        @(negedge ext_clk_25m);
        report_en = 1'b0;
        led_in    = 8'h10;
        tl0 = n_txlow;
        repeat (50) @(negedge ext_clk_25m);
        chk_eq("gate.tx_held", n_txlow - tl0, 32'd0);
        chk_eq("gate.busy", {31'd0, busy}, 32'd0);
        fd0 = n_fdone;
        report_en = 1'b1;
        recv_frame(8'h10, 6, "f10", NBYTES);
        wait_fdone(fd0, "f10");

        // Format check on a mixed pattern plus busy duration
        fd0 = n_fdone;
        b0  = n_busy;
        @(negedge ext_clk_25m);
        led_in = 8'hA5;
        recv_frame(8'hA5, 6, "fA5", NBYTES);
        wait_fdone(fd0, "fA5");
        repeat (3) @(negedge ext_clk_25m);
        lo = NBYTES * 10 * CPB;
        hi = NBYTES * (10 * CPB + 4);
        chk_eq("fA5.busy_len_in_range",
               {31'd0, ((n_busy - b0) >= lo) && ((n_busy - b0) <= hi)}, 32'd1);

        // Reset during byte 5 aborts the frame at once; a fresh frame follows
        fd0 = n_fdone;
        @(negedge ext_clk_25m);
        led_in = 8'h3C;
        recv_frame(8'h3C, 6, "pre", 5);
        repeat (20) @(negedge ext_clk_25m);
        #5;
        ext_rst_n = 1'b0;
        #1;
        chk_eq("abort.uart_tx", {31'd0, uart_tx}, 32'd1);
        chk_eq("abort.busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge ext_clk_25m);
        ext_rst_n = 1'b1;
        recv_frame(8'h3C, 10, "post", NBYTES);
        wait_fdone(fd0, "post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
